// File: rtl/fft_seq_core_if.sv
// fft_seq_core_if: sample-in / bin-out valid-ready bundle for fft_seq_core.
// The core uses the slave side; the producer/consumer side uses master.
interface fft_seq_core_if #(
   parameter int sample_size = 32,
   parameter int idx_w       = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic signed [sample_size-1:0] in_real;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [sample_size-1:0] out_real;
   logic signed [sample_size-1:0] out_imag;
   logic [idx_w-1:0]              out_index;
   logic                          out_last;

   modport master (
      output in_valid, in_real, out_ready,
      input  in_ready, out_valid, out_real,
      input  out_imag, out_index, out_last
   );

   modport slave (
      input  in_valid, in_real, out_ready,
      output in_ready, out_valid, out_real,
      output out_imag, out_index, out_last
   );
endinterface

// File: rtl/fft_seq_core.sv
// fft_seq_core: in-place radix-2 DIT FFT with one time-shared butterfly.
// Define FFT_STAGE_SCALE_EN to halve both butterfly outputs every stage.
module fft_seq_core #(
   parameter int sample_size   = 32,
   parameter int buffer_size   = 16,
   parameter int twiddle_size  = 16,
   parameter int no_float_mult = 1000
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [(buffer_size/2)*twiddle_size-1:0] twiddles_real,
   input  logic [(buffer_size/2)*twiddle_size-1:0] twiddles_imag,
   output logic                                   busy,
   fft_seq_core_if.slave                          bus
);
   localparam int S    = sample_size;
   localparam int T    = twiddle_size;
   localparam int N    = buffer_size;
   localparam int HN   = N / 2;
   localparam int LOGN = $clog2(N);
   localparam int SW   = $clog2(LOGN);
   localparam int PW   = S + T + 1;
   localparam logic signed [PW-1:0] NFM = PW'(no_float_mult);
`ifdef FFT_STAGE_SCALE_EN
   localparam int SH = 1;
`else
   localparam int SH = 0;
`endif

   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

   state_t              r_state, w_next;
   logic [LOGN-1:0]     r_cnt;
   logic [LOGN-2:0]     r_bf;
   logic [SW-1:0]       r_stage;
   logic signed [S-1:0] r_re [N];
   logic signed [S-1:0] r_im [N];

   logic                w_in_acc, w_out_acc, w_ov;
   logic                w_cnt_last, w_bf_last, w_done;
   logic [LOGN-1:0]     w_rev, w_half, w_p, w_q;
   logic [LOGN-2:0]     w_hm, w_k, w_tw;
   logic [SW-1:0]       w_tsh;
   logic signed [T-1:0] w_twr [HN];
   logic signed [T-1:0] w_twi [HN];
   logic signed [PW-1:0] w_ar, w_ai, w_br, w_bi;
   logic signed [PW-1:0] w_wr, w_wi, w_tr, w_ti;
   logic signed [S-1:0] w_na_r, w_na_i, w_nb_r, w_nb_i;

   function automatic logic signed [PW-1:0] sxs(
      input logic signed [S-1:0] v
   );
      return {{(PW-S){v[S-1]}}, v};
   endfunction

   function automatic logic signed [PW-1:0] sxt(
      input logic signed [T-1:0] v
   );
      return {{(PW-T){v[T-1]}}, v};
   endfunction

   assign w_ov       = (r_state == OUTPUT);
   assign w_in_acc   = (r_state == LOAD) && bus.in_valid;
   assign w_out_acc  = w_ov && bus.out_ready;
   assign w_cnt_last = (r_cnt == LOGN'(N-1));
   assign w_bf_last  = (r_bf == (LOGN-1)'(HN-1));
   assign w_done     = w_bf_last && (r_stage == SW'(LOGN-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         LOAD:    if (w_in_acc && w_cnt_last) w_next = COMPUTE;
         COMPUTE: if (w_done) w_next = OUTPUT;
         OUTPUT:  if (w_out_acc && w_cnt_last) w_next = LOAD;
         default: w_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_bf    <= '0;
         r_stage <= '0;
      end else begin
         if (w_in_acc || w_out_acc) r_cnt <= r_cnt + LOGN'(1);
         if (r_state == COMPUTE) begin
            r_bf <= r_bf + (LOGN-1)'(1);
            if (w_bf_last)
               r_stage <= w_done ? '0 : r_stage + SW'(1);
         end
      end
   end

   always_comb begin
      w_rev = '0;
      for (int i = 0; i < LOGN; i++) w_rev[i] = r_cnt[LOGN-1-i];
   end

   always_comb begin
      for (int i = 0; i < HN; i++) begin
         w_twr[i] = twiddles_real[i*T +: T];
         w_twi[i] = twiddles_imag[i*T +: T];
      end
   end

   // Butterfly j of stage s: k = j mod 2^s, group bits shifted up one.
   assign w_half = LOGN'(1) << r_stage;
   assign w_hm   = w_half[LOGN-2:0] - (LOGN-1)'(1);
   assign w_k    = r_bf & w_hm;
   assign w_tsh  = SW'(LOGN-1) - r_stage;
   assign w_tw   = w_k << w_tsh;
   assign w_p    = {r_bf & ~w_hm, 1'b0} | {1'b0, w_k};
   assign w_q    = w_p | w_half;

   assign w_ar = sxs(r_re[w_p]);
   assign w_ai = sxs(r_im[w_p]);
   assign w_br = sxs(r_re[w_q]);
   assign w_bi = sxs(r_im[w_q]);
   assign w_wr = sxt(w_twr[w_tw]);
   assign w_wi = sxt(w_twi[w_tw]);

   assign w_tr = (w_br * w_wr - w_bi * w_wi) / NFM;
   assign w_ti = (w_br * w_wi + w_bi * w_wr) / NFM;

   assign w_na_r = S'((w_ar + w_tr) >>> SH);
   assign w_na_i = S'((w_ai + w_ti) >>> SH);
   assign w_nb_r = S'((w_ar - w_tr) >>> SH);
   assign w_nb_i = S'((w_ai - w_ti) >>> SH);

   // Sample storage has no reset; contents are don't-care until loaded.
   always_ff @(posedge clk) begin
      if (w_in_acc) begin
         r_re[w_rev] <= bus.in_real;
         r_im[w_rev] <= '0;
      end else if (r_state == COMPUTE) begin
         r_re[w_p] <= w_na_r;
         r_im[w_p] <= w_na_i;
         r_re[w_q] <= w_nb_r;
         r_im[w_q] <= w_nb_i;
      end
   end

   assign busy          = (r_state == COMPUTE);
   assign bus.in_ready  = (r_state == LOAD);
   assign bus.out_valid = w_ov;
   assign bus.out_last  = w_ov && w_cnt_last;
   assign bus.out_index = w_ov ? r_cnt : '0;
   assign bus.out_real  = w_ov ? r_re[r_cnt] : '0;
   assign bus.out_imag  = w_ov ? r_im[r_cnt] : '0;
endmodule
